clic_reg_master: RTL
====================

CLIC_REG_MASTER -- requirements
Module: clic_reg_master

Interface
REQ-001 SHALL have parameter reg_req_t, default clic_synth_pkg::reg_req_t, meaning register-bus request struct: addr[31:0], write, wdata[31:0], wstrb[3:0], valid.
REQ-002 SHALL have parameter reg_rsp_t, default clic_synth_pkg::reg_rsp_t, meaning register-bus response struct: rdata[31:0], error, ready.
REQ-003 SHALL have parameter TimeoutCycles, default 1024, meaning max cycles a request waits for ready; 0 disables timeout.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_valid_i  in  1  command offered.
REQ-007 SHALL have port cmd_ready_o  out  1  command accepted when valid&&ready.
REQ-008 SHALL have port cmd_addr_i  in  32  target byte address.
REQ-009 SHALL have port cmd_write_i  in  1  1=write, 0=read.
REQ-010 SHALL have port cmd_wdata_i  in  32  write data.
REQ-011 SHALL have port cmd_wstrb_i  in  4  byte strobes (writes only).
REQ-012 SHALL have port rsp_valid_o  out  1  response available.
REQ-013 SHALL have port rsp_ready_i  in  1  response consumed when valid&&ready.
REQ-014 SHALL have port rsp_rdata_o  out  32  read data (0 for writes and timeouts).
REQ-015 SHALL have port rsp_error_o  out  1  slave error or timeout.
REQ-016 SHALL have port rsp_timeout_o  out  1  transaction aborted by timeout.
REQ-017 SHALL have port reg_req_o  out  reg_req_t  register-bus request toward CLIC register file.
REQ-018 SHALL have port reg_rsp_i  in  reg_rsp_t  register-bus response from CLIC register file.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, RSP; at most one outstanding transaction.
REQ-020 IDLE: cmd_ready_o=1; on cmd_valid_i register addr/write/wdata/wstrb (wstrb forced 4'h0 for reads), clear wait counter, go REQ next cycle.
REQ-021 cmd_ready_o SHALL be 0 in REQ and RSP; no combinational path from cmd_valid_i to cmd_ready_o.
REQ-022 REQ: reg_req_o.valid=1 with registered fields held stable until handshake or timeout.
REQ-023 REQ with reg_rsp_i.ready=1: capture rdata (reads only, else 0) and error, timeout flag=0, go RSP; minimum cmd-accept to rsp_valid_o latency is 2 cycles.
REQ-024 REQ with ready=0: wait counter increments by 1; counter width $clog2(TimeoutCycles+1), saturating, never wraps.
REQ-025 If TimeoutCycles!=0 and counter reaches TimeoutCycles-1 with ready still 0: drop valid next cycle, set rsp_error=1, rsp_timeout=1, rdata=0, go RSP.
REQ-026 Ready and timeout in the same cycle: ready SHALL win (normal completion, timeout=0).
REQ-027 RSP: rsp_valid_o=1, response outputs held stable; on rsp_ready_i go IDLE next cycle.
REQ-028 reg_req_o.valid SHALL be 0 in IDLE and RSP; reg_req_o fields other than valid are don't-care there but SHALL be driven from registers (no X).
REQ-029 reg_rsp_i SHALL be ignored outside REQ.

Reset
REQ-030 With rst_ni=0 at a clock edge: state=IDLE, counter=0, all captured registers 0; after that edge cmd_ready_o=1, rsp_valid_o=0, reg_req_o all-zero.
REQ-031 Reset asserted mid-transaction (REQ or RSP) SHALL abort it with no response emitted.

Verification
REQ-032 Read, slave ready same cycle as first valid, rdata=0xDEADBEEF -> rsp_valid_o 2 cycles after accept, rdata=0xDEADBEEF, error=0, timeout=0.
REQ-033 Write addr=0x1004 wdata=0x000000A5 wstrb=4'h1, ready after 3 wait cycles -> reg_req_o stable 4 cycles, rsp rdata=0, error=0.
REQ-034 TimeoutCycles=8, slave never ready -> valid high exactly 8 cycles, then rsp error=1, timeout=1, rdata=0.
REQ-035 TimeoutCycles=8, ready in the 8th valid cycle with error=1 -> rsp error=1, timeout=0.
REQ-036 rsp_ready_i low 5 cycles in RSP, new cmd_valid_i held -> outputs stable, cmd_ready_o=0 until return to IDLE.
REQ-037 rst_ni pulsed low in REQ -> next cycle reg_req_o.valid=0, cmd_ready_o=1, no rsp_valid_o.

Source files
------------

// File: rtl/clic_synth_pkg.sv
// Register-bus types shared by the CLIC register master and its users.
//   reg_req_t : request toward the CLIC register file (addr, write, wdata, wstrb, valid)
//   reg_rsp_t : response from the CLIC register file (rdata, error, ready)
package clic_synth_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/clic_reg_master.sv
// clic_reg_master: turns single command/response handshakes into register-bus
// transactions toward the CLIC register file. At most one transaction is in
// flight. A request that sees no ready for TimeoutCycles valid cycles is
// aborted and answered with error+timeout.
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   cmd_*                 command channel (valid/ready, addr, write, wdata, wstrb)
//   rsp_*                 response channel (valid/ready, rdata, error, timeout)
//   reg_req_o, reg_rsp_i  register-bus request/response
//   state_dbg             current FSM state (IDLE=0, REQ=1, RSP=2)
//
// Handshakes: every channel transfers on a rising edge where valid && ready
// are both high. A valid, once raised, keeps its payload stable until that
// transfer (or, for reg_req_o, until timeout). cmd_ready_o and rsp_valid_o
// depend on state only, never combinationally on the other side's signals.
module clic_reg_master #(
  parameter type         reg_req_t     = clic_synth_pkg::reg_req_t,
  parameter type         reg_rsp_t     = clic_synth_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        rsp_timeout_o,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i,
  output logic [1:0]  state_dbg
);

  // A zero-width counter is illegal, so a disabled timeout still keeps one bit.
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]     addr_q;
  logic            write_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [31:0]     rdata_q;
  logic            error_q;
  logic            timeout_q;
  logic [CntW-1:0] cnt_q;

  logic accept;
  logic complete;
  logic expire;

  // Next state and transaction events
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ready is checked first so it wins over a simultaneous timeout.
        if (reg_rsp_i.ready) begin
          complete = 1'b1;
          state_d  = RSP;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          expire  = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured command, response and wait counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr_i;
        write_q <= cmd_write_i;
        wdata_q <= cmd_wdata_i;
        wstrb_q <= cmd_write_i ? cmd_wstrb_i : 4'h0;
        cnt_q   <= '0;
      end
      if (state_q == REQ && !reg_rsp_i.ready && cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (complete) begin
        rdata_q   <= write_q ? 32'h0 : reg_rsp_i.rdata;
        error_q   <= reg_rsp_i.error;
        timeout_q <= 1'b0;
      end else if (expire) begin
        rdata_q   <= 32'h0;
        error_q   <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = write_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = wstrb_q;
    reg_req_o.valid = (state_q == REQ);
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_error_o   = error_q;
  assign rsp_timeout_o = timeout_q;
  assign state_dbg     = state_q;

endmodule
